// File: rtl/digit_pkg.sv
// Shared definitions for the digit-pick sequencer.
// Holds the line-buffer geometry, datapath widths, the one-hot state
// encoding and the decimal shift-and-add helper used to build a line value.
package digit_pkg;

    localparam int LINE_MAX = 100;
    localparam int ADR_W    = 8;
    localparam int SUM_W    = 64;
    localparam int NDIG_W   = 4;

    // Search lower bound meaning "before index 0"; +1 wraps to address 0.
    localparam logic [ADR_W-1:0] ADR_NONE = '1;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_CAPT  = 5'b00100,
        ST_ACCUM = 5'b01000,
        ST_FIN   = 5'b10000
    } state_t;

    // v*10 + d built from shifts so no multiplier is inferred.
    function automatic logic [SUM_W-1:0] mul10_add(input logic [SUM_W-1:0] v,
                                                   input logic [3:0]       d);
        return (v << 3) + (v << 1) + SUM_W'(d);
    endfunction

endpackage

// File: rtl/digit_pick_ctrl.sv
// Digit-pick sequencer.
// For one line of the right-aligned BCD buffer, issues n_digits successive
// windows to the external max-digit search, captures each winner, builds the
// line value in binary and adds it into a running sum.
//
// Ports:
//   sysclk, reset_n            clock, synchronous active-low reset
//   start                      begin a line (sampled only in IDLE)
//   n_digits, line_len         line configuration, stable while busy
//   clr_sum                    zero the running sum
//   search_prev_adr/mask       window driven to the search
//   search_max_val/adr         search result
//   busy, done, err            status; err qualifies done
//   line_value, sum            last line value and running total
//
// state  | meaning
// IDLE   | waiting for start, configuration checked here
// ISSUE  | window registers drive the search, result settles
// CAPT   | capture digit/address, extend line value
// ACCUM  | add line value into sum
// FIN    | one-cycle done pulse (err for a rejected line)
module digit_pick_ctrl
    import digit_pkg::*;
(
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [NDIG_W-1:0] n_digits,
    input  logic [6:0]        line_len,
    input  logic              clr_sum,
    output logic [ADR_W-1:0]  search_prev_adr,
    output logic [ADR_W-1:0]  search_mask,
    input  logic [3:0]        search_max_val,
    input  logic [ADR_W-1:0]  search_max_adr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SUM_W-1:0]  line_value,
    output logic [SUM_W-1:0]  sum
);

    state_t            state_q;
    state_t            state_d;
    logic [NDIG_W-1:0] k_q;
    logic [ADR_W-1:0]  prev_q;
    logic [ADR_W-1:0]  mask_q;
    logic              err_q;
    logic              cfg_bad;
    logic              last_digit;
    logic [ADR_W-1:0]  capt_adr;

    assign cfg_bad = (n_digits == '0) || (line_len == '0) ||
                     (line_len > 7'(LINE_MAX)) || (7'(n_digits) > line_len);

    assign last_digit = (k_q == n_digits - NDIG_W'(1));

    // A zero digit means no winner: the search reports address 0, so the
    // window simply advances by one position.
    assign capt_adr = (search_max_val == 4'd0) ? prev_q + ADR_W'(1) : search_max_adr;

    assign search_prev_adr = prev_q;
    assign search_mask     = mask_q;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = cfg_bad ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy    = 1'b1;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                busy    = 1'b1;
                state_d = last_digit ? ST_ACCUM : ST_ISSUE;
            end
            ST_ACCUM: begin
                busy    = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err = done & err_q;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            k_q        <= '0;
            prev_q     <= ADR_NONE;
            mask_q     <= '0;
            err_q      <= 1'b0;
            line_value <= '0;
            sum        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= cfg_bad;
                        if (!cfg_bad) begin
                            k_q        <= '0;
                            line_value <= '0;
                            // Wraps to ADR_NONE for a full-length line.
                            prev_q     <= ADR_W'(LINE_MAX - 1) - ADR_W'(line_len);
                            mask_q     <= ADR_W'(n_digits) - ADR_W'(1);
                        end
                    end
                end
                ST_CAPT: begin
                    line_value <= mul10_add(line_value, search_max_val);
                    prev_q     <= capt_adr;
                    if (!last_digit) begin
                        k_q    <= k_q + NDIG_W'(1);
                        mask_q <= mask_q - ADR_W'(1);
                    end
                end
                default: ;
            endcase

            // Clear coincident with ACCUM still counts the current line.
            if (state_q == ST_ACCUM) begin
                sum <= clr_sum ? line_value : sum + line_value;
            end else if (clr_sum) begin
                sum <= '0;
            end
        end
    end

endmodule

// File: tb/tb_digit_pick_ctrl.sv
module tb_digit_pick_ctrl;
    import digit_pkg::*;

    logic              sysclk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [NDIG_W-1:0] n_digits;
    logic [6:0]        line_len;
    logic              clr_sum;
    logic [ADR_W-1:0]  search_prev_adr;
    logic [ADR_W-1:0]  search_mask;
    logic [3:0]        search_max_val;
    logic [ADR_W-1:0]  search_max_adr;
    logic              busy;
    logic              done;
    logic              err;
    logic [SUM_W-1:0]  line_value;
    logic [SUM_W-1:0]  sum;

    logic [3:0] line_buf [LINE_MAX];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc;
    logic       seen_done;

    always #5 sysclk = ~sysclk;

    digit_pick_ctrl dut (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .start           (start),
        .n_digits        (n_digits),
        .line_len        (line_len),
        .clr_sum         (clr_sum),
        .search_prev_adr (search_prev_adr),
        .search_mask     (search_mask),
        .search_max_val  (search_max_val),
        .search_max_adr  (search_max_adr),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .line_value      (line_value),
        .sum             (sum)
    );

    // Search model: leftmost maximum in (prev_adr, LINE_MAX-1-mask];
    // all-zero window reports value 0 at address 0.
    int         s_lo;
    int         s_hi;
    logic [3:0] s_val;
    logic [7:0] s_adr;
    always_comb begin
        s_lo  = int'(8'(search_prev_adr + 8'd1));
        s_hi  = LINE_MAX - 1 - int'(search_mask);
        s_val = 4'd0;
        s_adr = 8'd0;
        for (int i = 0; i < LINE_MAX; i++) begin
            if (i >= s_lo && i <= s_hi && line_buf[i] > s_val) begin
                s_val = line_buf[i];
                s_adr = 8'(i);
            end
        end
        search_max_val = s_val;
        search_max_adr = s_adr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_line(input string s);
        int l;
        l = s.len();
        for (int i = 0; i < LINE_MAX; i++) line_buf[i] = 4'd0;
        for (int i = 0; i < l; i++) line_buf[LINE_MAX - l + i] = 4'(s[i] - 8'd48);
    endtask

    // Starts a line and returns the number of edges from start to done.
    task automatic run_line(input string s, input int n, output int c);
        load_line(s);
        @(negedge sysclk);
        n_digits = NDIG_W'(n);
        line_len = 7'(s.len());
        start    = 1'b1;
        @(posedge sysclk);
        c = 1;
        @(negedge sysclk);
        start = 1'b0;
        while (!done && c < 200) begin
            @(posedge sysclk);
            c++;
            @(negedge sysclk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        clr_sum  = 1'b0;
        n_digits = '0;
        line_len = '0;
        load_line("0");
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_lv", line_value, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_prev", 64'(search_prev_adr), 64'd255);
        chk("rst_mask", 64'(search_mask), 64'd0);
        reset_n = 1'b1;

        run_line("987654321111111", 2, cyc);
        chk("l1_cyc", 64'(cyc), 64'd6);
        chk("l1_done", 64'(done), 64'd1);
        chk("l1_busy", 64'(busy), 64'd0);
        chk("l1_err", 64'(err), 64'd0);
        chk("l1_lv", line_value, 64'd98);
        chk("l1_sum", sum, 64'd98);

        run_line("987654321111111", 12, cyc);
        chk("l12_cyc", 64'(cyc), 64'd26);
        chk("l12_lv", line_value, 64'd987654321111);
        chk("l12_sum", sum, 64'd987654321209);

        @(negedge sysclk);
        clr_sum = 1'b1;
        @(negedge sysclk);
        clr_sum = 1'b0;
        chk("clr_sum", sum, 64'd0);

        run_line("987654321111111", 2, cyc);
        chk("m1_lv", line_value, 64'd98);
        run_line("811111111111119", 2, cyc);
        chk("m2_lv", line_value, 64'd89);
        run_line("234234234234278", 2, cyc);
        chk("m3_lv", line_value, 64'd78);
        run_line("818181911112111", 2, cyc);
        chk("m4_lv", line_value, 64'd92);
        chk("m_sum", sum, 64'd357);

        run_line("0000", 2, cyc);
        chk("z_cyc", 64'(cyc), 64'd6);
        chk("z_lv", line_value, 64'd0);
        chk("z_prev", 64'(search_prev_adr), 64'd97);
        chk("z_sum", sum, 64'd357);

        run_line("123", 5, cyc);
        chk("b5_cyc", 64'(cyc), 64'd1);
        chk("b5_done", 64'(done), 64'd1);
        chk("b5_err", 64'(err), 64'd1);
        chk("b5_sum", sum, 64'd357);
        @(negedge sysclk);
        chk("b5_done_off", 64'(done), 64'd0);
        chk("b5_err_off", 64'(err), 64'd0);

        run_line("123", 0, cyc);
        chk("b0_cyc", 64'(cyc), 64'd1);
        chk("b0_err", 64'(err), 64'd1);
        chk("b0_sum", sum, 64'd357);

        // Reset while in CAPT.
        load_line("987654321111111");
        @(negedge sysclk);
        n_digits = 4'd2;
        line_len = 7'd15;
        start    = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start = 1'b0;
        chk("r_busy_run", 64'(busy), 64'd1);
        @(posedge sysclk);
        @(negedge sysclk);
        reset_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_lv", line_value, 64'd0);
        chk("r_sum", sum, 64'd0);
        chk("r_prev", 64'(search_prev_adr), 64'd255);
        chk("r_mask", 64'(search_mask), 64'd0);
        reset_n   = 1'b1;
        seen_done = done;
        repeat (4) begin
            @(posedge sysclk);
            @(negedge sysclk);
            seen_done = seen_done | done;
        end
        chk("r_no_done", 64'(seen_done), 64'd0);
        run_line("987654321111111", 2, cyc);
        chk("r_next_cyc", 64'(cyc), 64'd6);
        chk("r_next_lv", line_value, 64'd98);
        chk("r_next_sum", sum, 64'd98);

        run_line("02", 2, cyc);
        chk("t_lv", line_value, 64'd2);
        chk("t_sum", sum, 64'd100);

        // clr_sum coincident with ACCUM.
        load_line("987654321111111");
        @(negedge sysclk);
        n_digits = 4'd2;
        line_len = 7'd15;
        start    = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start = 1'b0;
        repeat (4) begin
            @(posedge sysclk);
            @(negedge sysclk);
        end
        clr_sum = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        clr_sum = 1'b0;
        chk("ca_done", 64'(done), 64'd1);
        chk("ca_sum", sum, 64'd98);
        chk("ca_lv", line_value, 64'd98);
        @(negedge sysclk);
        chk("ca_sum_hold", sum, 64'd98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
